fp_normalizer: RTL and testbench

//   Post-add normalization stage of the FP adder: inverse of the alignment step. Alignment right-shifts
//   the smaller operand to the bigger exponent; this block takes the raw mantissa sum, restores the

---
 rtl/fp_normalizer.sv | 151 +++++++++++++++
 tb/tb_fp_normalizer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
//==============================================================================
// Module  : fp_normalizer
// Brief   : Post-add FP normalization stage: restores the hidden-1 position of
//           a raw mantissa sum and adjusts the exponent, valid/ready both sides.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_normalizer #(
    parameter int EXP_BITS  = 8,
    parameter int FRAC_BITS = 23,
    parameter int SW        = $clog2(FRAC_BITS + 2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_BITS-1:0]           in_exp,
    input  logic [FRAC_BITS+1:0]          in_mant,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_BITS+FRAC_BITS:0]   out_result,
    output logic                          out_ovf,
    output logic                          out_uf,
    output logic [SW-1:0]                 out_shift
);

    localparam int                   MW      = FRAC_BITS + 2;
    localparam logic [EXP_BITS-1:0]  EXP_MAX = '1;
    localparam logic [EXP_BITS-1:0]  EXP_ONE = EXP_BITS'(1);
    localparam logic [SW-1:0]        SH_ONE  = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state, w_state_n;
    logic                  r_sign,  w_sign_n;
    logic [EXP_BITS-1:0]   r_exp,   w_exp_n;
    logic [MW-1:0]         r_mant,  w_mant_n;
    logic [SW-1:0]         r_shift, w_shift_n;
    logic                  r_ovf,   w_ovf_n;
    logic                  r_uf,    w_uf_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_mant  <= '0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sign  <= w_sign_n;
            r_exp   <= w_exp_n;
            r_mant  <= w_mant_n;
            r_shift <= w_shift_n;
            r_ovf   <= w_ovf_n;
            r_uf    <= w_uf_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sign_n  = r_sign;
        w_exp_n   = r_exp;
        w_mant_n  = r_mant;
        w_shift_n = r_shift;
        w_ovf_n   = r_ovf;
        w_uf_n    = r_uf;

        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_sign_n  = in_sign;
                    w_exp_n   = in_exp;
                    w_mant_n  = in_mant;
                    w_shift_n = '0;
                    w_ovf_n   = 1'b0;
                    w_uf_n    = 1'b0;
                    w_state_n = S_CHECK;
                end
            end

            S_CHECK: begin
                if (r_mant == '0 || r_exp == '0) begin
                    w_exp_n   = '0;
                    w_mant_n  = '0;
                    w_uf_n    = 1'b1;
                    w_state_n = S_DONE;
                end else if (r_mant[MW-1]) begin
                    // Comparing against MAX-1 also keeps an all-ones input exponent from wrapping.
                    if (r_exp >= EXP_MAX - EXP_ONE) begin
                        w_exp_n  = EXP_MAX;
                        w_mant_n = '0;
                        w_ovf_n  = 1'b1;
                    end else begin
                        w_exp_n  = r_exp + EXP_ONE;
                        w_mant_n = r_mant >> 1;
                    end
                    w_state_n = S_DONE;
                end else if (r_mant[FRAC_BITS]) begin
                    w_state_n = S_DONE;
                end else begin
                    w_state_n = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (r_exp == EXP_ONE) begin
                    w_exp_n   = '0;
                    w_mant_n  = '0;
                    w_uf_n    = 1'b1;
                    w_state_n = S_DONE;
                end else begin
                    w_mant_n  = r_mant << 1;
                    w_exp_n   = r_exp - EXP_ONE;
                    w_shift_n = r_shift + SH_ONE;
                    // Bit below hidden becomes the hidden bit after this shift.
                    if (r_mant[FRAC_BITS-1]) begin
                        w_state_n = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_n = S_IDLE;
                end
            end

            default: w_state_n = S_IDLE;
        endcase
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = {r_sign, r_exp, r_mant[FRAC_BITS-1:0]};
    assign out_ovf    = r_ovf;
    assign out_uf     = r_uf;
    assign out_shift  = r_shift;

endmodule

`default_nettype wire

// File: tb/tb_fp_normalizer.sv
//==============================================================================
// Module  : tb_fp_normalizer
// Brief   : Directed self-checking bench for fp_normalizer (single precision).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_uf;
    logic [4:0]  out_shift;

    int checks = 0;
    int fails  = 0;

    fp_normalizer #(
        .EXP_BITS  (8),
        .FRAC_BITS (23)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_uf     (out_uf),
        .out_shift  (out_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one sum (DUT must be idle); lat = edges after the accepting edge
    // until out_valid is seen, 100 on timeout. Called and returns at posedge+1.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        output int lat);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 00000000", out_result); end
        checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        checks++; if (out_uf !== 1'b0) begin fails++; $display("FAIL reset_uf: got %b want 0", out_uf); end
        checks++; if (out_shift !== 5'd0) begin fails++; $display("FAIL reset_shift: got %0d want 0", out_shift); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_unity();
        int lat;
        send(1'b0, 8'd127, 25'h0800000, lat);
        checks++; if (lat != 1) begin fails++; $display("FAIL unity_latency: got %0d want 1", lat); end
        checks++; if (out_result !== 32'h3F800000) begin fails++; $display("FAIL unity_result: got %h want 3F800000", out_result); end
        checks++; if (out_shift !== 5'd0) begin fails++; $display("FAIL unity_shift: got %0d want 0", out_shift); end
        checks++; if (out_ovf !== 1'b0 || out_uf !== 1'b0) begin fails++; $display("FAIL unity_flags: got ovf=%b uf=%b want 0 0", out_ovf, out_uf); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL unity_busy: in_ready got %b want 0", in_ready); end
        consume();
    endtask

    task automatic test_carry();
        int lat;
        send(1'b0, 8'd127, 25'h1000000, lat);
        checks++; if (lat != 1) begin fails++; $display("FAIL carry_latency: got %0d want 1", lat); end
        checks++; if (out_result !== 32'h40000000) begin fails++; $display("FAIL carry_result: got %h want 40000000", out_result); end
        checks++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL carry_ovf: got %b want 0", out_ovf); end
        consume();
        // LSB dropped on the carry shift, no rounding
        send(1'b0, 8'd127, 25'h1000001, lat);
        checks++; if (out_result !== 32'h40000000) begin fails++; $display("FAIL carry_trunc: got %h want 40000000", out_result); end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        send(1'b0, 8'd254, 25'h1000000, lat);
        checks++; if (lat != 1) begin fails++; $display("FAIL ovf_latency: got %0d want 1", lat); end
        checks++; if (out_result !== 32'h7F800000) begin fails++; $display("FAIL ovf_result: got %h want 7F800000", out_result); end
        checks++; if (out_ovf !== 1'b1 || out_uf !== 1'b0) begin fails++; $display("FAIL ovf_flags: got ovf=%b uf=%b want 1 0", out_ovf, out_uf); end
        consume();
    endtask

    task automatic test_max_shift();
        int lat;
        send(1'b0, 8'd127, 25'h0000001, lat);
        checks++; if (lat != 24) begin fails++; $display("FAIL maxshift_latency: got %0d want 24", lat); end
        checks++; if (out_result !== 32'h34000000) begin fails++; $display("FAIL maxshift_result: got %h want 34000000", out_result); end
        checks++; if (out_shift !== 5'd23) begin fails++; $display("FAIL maxshift_count: got %0d want 23", out_shift); end
        consume();
    endtask

    task automatic test_zero();
        int lat;
        send(1'b1, 8'd127, 25'h0000000, lat);
        checks++; if (lat != 1) begin fails++; $display("FAIL zero_latency: got %0d want 1", lat); end
        checks++; if (out_result !== 32'h80000000) begin fails++; $display("FAIL zero_result: got %h want 80000000", out_result); end
        checks++; if (out_uf !== 1'b1 || out_ovf !== 1'b0) begin fails++; $display("FAIL zero_flags: got ovf=%b uf=%b want 0 1", out_ovf, out_uf); end
        consume();
    endtask

    task automatic test_underflow();
        int lat;
        // exp 3 -> 2 -> 1 after two shifts, then flush
        send(1'b0, 8'd3, 25'h0000010, lat);
        checks++; if (lat != 4) begin fails++; $display("FAIL uf_latency: got %0d want 4", lat); end
        checks++; if (out_result !== 32'h00000000) begin fails++; $display("FAIL uf_result: got %h want 00000000", out_result); end
        checks++; if (out_uf !== 1'b1) begin fails++; $display("FAIL uf_flag: got %b want 1", out_uf); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        send(1'b0, 8'd128, 25'h0C00000, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sign  = 1'b1;
            in_exp   = 8'd10;
            in_mant  = 25'h0000003;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_result !== 32'h40400000)
                begin fails++; $display("FAIL hold_output[%0d]: got valid=%b result=%h want 1 40400000", i, out_valid, out_result); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL hold_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_no_capture: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_abort();
        int lat;
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_mant  = 25'h0000001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
            begin fails++; $display("FAIL abort_busy: got valid=%b ready=%b want 0 0", out_valid, in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_shift !== 5'd0)
            begin fails++; $display("FAIL abort_reset: got valid=%b ready=%b shift=%0d want 0 1 0", out_valid, in_ready, out_shift); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 8'd127, 25'h0800000, lat);
        checks++; if (lat != 1 || out_result !== 32'h3F800000)
            begin fails++; $display("FAIL abort_recover: got lat=%0d result=%h want 1 3F800000", lat, out_result); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(1'b0, 8'd100, 25'h0400000, lat);
        checks++; if (lat != 2 || out_result !== 32'h31800000 || out_shift !== 5'd1)
            begin fails++; $display("FAIL b2b_first: got lat=%0d result=%h shift=%0d want 2 31800000 1", lat, out_result, out_shift); end
        consume();
        send(1'b1, 8'd130, 25'h1C00000, lat);
        checks++; if (lat != 1 || out_result !== 32'hC1E00000 || out_shift !== 5'd0)
            begin fails++; $display("FAIL b2b_second: got lat=%0d result=%h shift=%0d want 1 C1E00000 0", lat, out_result, out_shift); end
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_unity();
        test_carry();
        test_overflow();
        test_max_shift();
        test_zero();
        test_underflow();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
